bus_fabric: RTL and testbench

- Parametrised successor to the single-master peripheral bus: a registered, handshaked interconnect between NUM_M masters and NUM_S slaves.
- Example masters: CPU data port, plus a DMA or debug port.
- Replaces the tri-state shared data line with separate write and read paths.
- Adds round-robin arbitration, slave wait states, unmapped-address error responses and an optional access timeout.
- Sits between the core/load-store unit and the RAM and peripheral blocks.

---
 rtl/bus_fabric_if.sv | 36 +++
 rtl/bus_fabric.sv | 117 +++++++++++
 tb/tb_bus_fabric.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/bus_fabric_if.sv
// bus_fabric_if: master-side and slave-side signals of the bus fabric.
// The fabric modport is the interconnect's view; master/slave are the agents' views.
interface bus_fabric_if #(
    parameter int NUM_M  = 2,
    parameter int NUM_S  = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [NUM_M-1:0]        m_req;
    logic [NUM_M-1:0]        m_we;
    logic [NUM_M*ADDR_W-1:0] m_addr;
    logic [NUM_M*DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0]       m_rdata;
    logic [NUM_M-1:0]        m_ack;
    logic [NUM_M-1:0]        m_err;
    logic [NUM_S-1:0]        s_sel;
    logic                    s_we;
    logic [ADDR_W-1:0]       s_addr;
    logic [DATA_W-1:0]       s_wdata;
    logic [NUM_S*DATA_W-1:0] s_rdata;
    logic [NUM_S-1:0]        s_ready;
    logic                    busy;

    modport fabric (
        input  m_req, m_we, m_addr, m_wdata, s_rdata, s_ready,
        output m_rdata, m_ack, m_err, s_sel, s_we, s_addr, s_wdata, busy
    );
    modport master (
        output m_req, m_we, m_addr, m_wdata,
        input  m_rdata, m_ack, m_err, busy
    );
    modport slave (
        input  s_sel, s_we, s_addr, s_wdata,
        output s_rdata, s_ready
    );
endinterface

// File: rtl/bus_fabric.sv
// bus_fabric: registered round-robin interconnect between NUM_M masters and NUM_S slaves.
// Optional access timeout enabled by defining BUS_TIMEOUT_EN.
module bus_fabric #(
    parameter int         NUM_M       = 2,
    parameter int         NUM_S       = 8,
    parameter int         ADDR_W      = 16,
    parameter int         DATA_W      = 32,
    parameter logic [7:0] PERIPH_PAGE = 8'hFF,
    parameter int         TIMEOUT_CYC = 255
) (
    input logic          clk,
    input logic          rst,
    bus_fabric_if.fabric bus
);
    localparam int GW = NUM_M > 1 ? $clog2(NUM_M) : 1;
    localparam int SW = NUM_S > 1 ? $clog2(NUM_S) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    state_t            state, state_n;
    logic [GW-1:0]     grant, last_grant, win;
    logic              found;
    logic [ADDR_W-1:0] win_addr, addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              we_q;
    logic              page_hit, mapped;
    int                pidx;
    logic [SW-1:0]     slv;
    logic              ready;
    logic              tmo;

    // Round-robin search starts just after the previous winner.
    always_comb begin
        found = 1'b0;
        win   = last_grant;
        for (int k = 0; k < NUM_M; k++) begin
            if (!found && bus.m_req[(int'(last_grant) + 1 + k) % NUM_M]) begin
                found = 1'b1;
                win   = GW'((int'(last_grant) + 1 + k) % NUM_M);
            end
        end
    end

    assign win_addr = bus.m_addr[win*ADDR_W +: ADDR_W];
    assign page_hit = win_addr[ADDR_W-1 -: 8] == PERIPH_PAGE;
    assign pidx     = int'(win_addr[7:4]) + 1;
    assign mapped   = !page_hit || pidx < NUM_S;
    assign ready    = bus.s_ready[slv];

`ifdef BUS_TIMEOUT_EN
    localparam int CW0  = $clog2(TIMEOUT_CYC + 1);
    localparam int CNT_W = CW0 < 8 ? 8 : (CW0 > 16 ? 16 : CW0);
    logic [CNT_W-1:0] cnt;
    assign tmo = cnt == CNT_W'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (state == IDLE)
            cnt <= '0;
        else if (state == ACCESS)
            cnt <= cnt + 1'b1;
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GW'(NUM_M - 1);
            grant      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            slv        <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && found) begin
                grant      <= win;
                last_grant <= win;
                we_q       <= bus.m_we[win];
                addr_q     <= win_addr;
                wdata_q    <= bus.m_wdata[win*DATA_W +: DATA_W];
                if (mapped)
                    slv <= page_hit ? SW'(pidx) : '0;
            end
            if (state == ACCESS && ready)
                rdata_q <= we_q ? '0 : bus.s_rdata[slv*DATA_W +: DATA_W];
        end
    end

    // A ready arriving together with the timeout still completes normally.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = found ? (mapped ? ACCESS : ERR) : IDLE;
            ACCESS:  state_n = ready ? RESP : (tmo ? ERR : ACCESS);
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.s_sel   = '0;
        bus.m_ack   = '0;
        bus.m_err   = '0;
        if (state == ACCESS)
            bus.s_sel[slv] = 1'b1;
        bus.m_ack[grant] = state == RESP || state == ERR;
        bus.m_err[grant] = state == ERR;
        bus.m_rdata = state == RESP ? rdata_q : '0;
        bus.busy    = state != IDLE;
        bus.s_we    = we_q;
        bus.s_addr  = addr_q;
        bus.s_wdata = wdata_q;
    end
endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: directed checks of arbitration, wait states, decode errors and reset.
module tb_bus_fabric;
`ifdef BUS_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passes = 0;

    bus_fabric_if #(.NUM_M(2), .NUM_S(8), .ADDR_W(16), .DATA_W(32)) bus ();

    bus_fabric #(
        .NUM_M(2), .NUM_S(8), .ADDR_W(16), .DATA_W(32),
        .PERIPH_PAGE(8'hFF), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        bus.m_req   = '0;
        bus.m_we    = '0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.s_ready = '0;
        bus.s_rdata = '0;
        bus.s_rdata[0*32 +: 32] = 32'h12345678;
        bus.s_rdata[7*32 +: 32] = 32'hCAFEF00D;
        tick;
        tick;
        chk("rst_busy", bus.busy, 0);
        chk("rst_sel", bus.s_sel, 0);
        chk("rst_ack", bus.m_ack, 0);
        chk("rst_we", bus.s_we, 0);
        chk("rst_addr", bus.s_addr, 0);
        rst = 1'b0;

        // Master 0 reads RAM, zero wait states
        bus.m_addr  = {16'h0000, 16'h0040};
        bus.m_req   = 2'b01;
        bus.s_ready = 8'h01;
        tick;
        chk("rd_sel", bus.s_sel, 8'h01);
        chk("rd_addr", bus.s_addr, 16'h0040);
        chk("rd_noack", bus.m_ack, 0);
        tick;
        chk("rd_ack", bus.m_ack, 2'b01);
        chk("rd_data", bus.m_rdata, 32'h12345678);
        chk("rd_err", bus.m_err, 0);
        chk("rd_sel_off", bus.s_sel, 0);
        bus.m_req = 2'b00;
        tick;
        chk("rd_idle", bus.busy, 0);

        // Master 0 writes LED with 3 stall cycles; request dropped early
        bus.m_addr  = {16'h0000, 16'hFF00};
        bus.m_wdata = {32'h0, 32'h000000A5};
        bus.m_we    = 2'b01;
        bus.m_req   = 2'b01;
        bus.s_ready = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("wr_sel%0d", i), bus.s_sel, 8'h02);
            chk($sformatf("wr_we%0d", i), bus.s_we, 1);
            chk($sformatf("wr_wd%0d", i), bus.s_wdata, 32'hA5);
            if (i == 1) bus.m_req = 2'b00;
            if (i == 3) bus.s_ready = 8'h02;
        end
        tick;
        chk("wr_ack", bus.m_ack, 2'b01);
        chk("wr_rdata", bus.m_rdata, 0);
        bus.s_ready = 8'h00;
        bus.m_we    = 2'b00;
        tick;

        // Highest mapped peripheral, low address bits pass through
        bus.m_addr  = {16'h0000, 16'hFF65};
        bus.m_req   = 2'b01;
        bus.s_ready = 8'h80;
        tick;
        chk("p7_sel", bus.s_sel, 8'h80);
        chk("p7_addr", bus.s_addr, 16'hFF65);
        tick;
        chk("p7_ack", bus.m_ack, 2'b01);
        chk("p7_data", bus.m_rdata, 32'hCAFEF00D);
        bus.m_req   = 2'b00;
        bus.s_ready = 8'h00;
        tick;

        // Master 1 hits unmapped peripheral index 7
        bus.m_addr = {16'hFF70, 16'h0000};
        bus.m_req  = 2'b10;
        tick;
        chk("um_ack", bus.m_ack, 2'b10);
        chk("um_err", bus.m_err, 2'b10);
        chk("um_sel", bus.s_sel, 0);
        chk("um_data", bus.m_rdata, 0);
        bus.m_req = 2'b00;
        tick;
        chk("um_idle", bus.busy, 0);

        // Both masters request continuously: strict alternation
        bus.m_addr  = {16'h0200, 16'h0100};
        bus.m_req   = 2'b11;
        bus.s_ready = 8'h01;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("rr_addr%0d", i), bus.s_addr, (i % 2) ? 16'h0200 : 16'h0100);
            tick;
            chk($sformatf("rr_ack%0d", i), bus.m_ack, (i % 2) ? 2'b10 : 2'b01);
            if (i == 3) bus.m_req = 2'b00;
            tick;
            chk($sformatf("rr_gap%0d", i), bus.busy, 0);
        end

        // Reset during ACCESS drops the transfer
        bus.m_addr  = {16'h0000, 16'h0040};
        bus.m_req   = 2'b01;
        bus.s_ready = 8'h00;
        tick;
        chk("mr_sel", bus.s_sel, 8'h01);
        rst = 1'b1;
        tick;
        chk("mr_sel0", bus.s_sel, 0);
        chk("mr_busy", bus.busy, 0);
        chk("mr_ack", bus.m_ack, 0);
        rst = 1'b0;
        bus.s_ready = 8'h01;
        tick;
        chk("mr_resel", bus.s_sel, 8'h01);
        tick;
        chk("mr_reack", bus.m_ack, 2'b01);
        chk("mr_data", bus.m_rdata, 32'h12345678);
        bus.m_req   = 2'b00;
        bus.s_ready = 8'h00;
        tick;

`ifdef BUS_TIMEOUT_EN
        // Slave 5 never ready: error after 4 ACCESS cycles
        bus.m_addr = {16'h0000, 16'hFF40};
        bus.m_req  = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("to_sel%0d", i), bus.s_sel, 8'h20);
        end
        tick;
        chk("to_ack", bus.m_ack, 2'b01);
        chk("to_err", bus.m_err, 2'b01);
        chk("to_sel", bus.s_sel, 0);
        bus.m_req = 2'b00;
        tick;
        // Ready on the final cycle beats the timeout
        bus.m_req = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("tr_sel%0d", i), bus.s_sel, 8'h20);
            if (i == 3) bus.s_ready = 8'h20;
        end
        tick;
        chk("tr_ack", bus.m_ack, 2'b01);
        chk("tr_err", bus.m_err, 0);
        bus.m_req   = 2'b00;
        bus.s_ready = 8'h00;
        tick;
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
